// File: rtl/pcie_csr_resp_pkg.sv
// Shared constants and response record for the PCIe feature CSR responder.
// Offsets are relative to the window base inside BAR0.
package pcie_csr_resp_pkg;

  localparam int unsigned CSR_BASE       = 32'h0001_0000;

  localparam int unsigned OFF_DFH        = 32'h00;
  localparam int unsigned OFF_SCRATCHPAD = 32'h08;
  localparam int unsigned OFF_TESTPAD    = 32'h28;
  localparam int unsigned OFF_CAP_STATUS = 32'h30;

  localparam int unsigned CAP_ATS_LSB    = 0;
  localparam int unsigned CAP_VF_ATS_LSB = 8;
  localparam int unsigned CAP_PRS_LSB    = 16;
  localparam int unsigned CAP_PASID_LSB  = 24;
  localparam int unsigned CAP_NPFS_LSB   = 32;
  localparam int unsigned CAP_NLINK_LSB  = 40;

  localparam int unsigned CSR_TAG_W      = 10;

  typedef struct packed {
    logic [63:0]          rdata;
    logic [CSR_TAG_W-1:0] tag;
    logic                 err;
  } t_csr_rsp;

endpackage

// File: rtl/pcie_csr_rsp_fifo.sv
// Two-entry in-order completion buffer; the head entry drives the response port.
module pcie_csr_rsp_fifo
  import pcie_csr_resp_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  t_csr_rsp push_data,
  input  logic     pop,
  output t_csr_rsp head,
  output logic [1:0] count
);

  t_csr_rsp mem [2];
  logic     wr_ptr;
  logic     rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pcie_csr_responder.sv
// MMIO responder for the PCIe feature CSR window: decode, register file,
// error counter, and a 2-deep in-order read-completion buffer.
module pcie_csr_responder
  import pcie_csr_resp_pkg::*;
#(
  parameter int unsigned NUM_PFS   = 8,
  parameter int unsigned NUM_LINKS = 1,
  parameter logic [63:0] DFH_VALUE = 64'h0,
  parameter logic [NUM_PFS-1:0] ATS_CAP_EN    = '0,
  parameter logic [NUM_PFS-1:0] VF_ATS_CAP_EN = '0,
  parameter logic [NUM_PFS-1:0] PRS_CAP_EN    = '0,
  parameter logic [NUM_PFS-1:0] PASID_CAP_EN  = '0,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned TAG_W  = 10
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_be,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic [15:0]       err_cnt
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [63:0] apply_be(input logic [63:0] old_val,
                                           input logic [63:0] new_val,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [ADDR_W-1:0] offset;
  logic              hit_dfh, hit_scratch, hit_testpad, hit_cap, mapped;
  logic              accept, push, pop;
  logic [63:0]       scratchpad, testpad;
  logic [63:0]       cap_status, rd_data;
  logic [1:0]        fifo_count;
  t_csr_rsp          push_data, head;

  assign offset      = req_addr - ADDR_W'(CSR_BASE);
  // Low address bits are part of the compare, so misaligned accesses miss.
  assign hit_dfh     = (offset == ADDR_W'(OFF_DFH));
  assign hit_scratch = (offset == ADDR_W'(OFF_SCRATCHPAD));
  assign hit_testpad = (offset == ADDR_W'(OFF_TESTPAD));
  assign hit_cap     = (offset == ADDR_W'(OFF_CAP_STATUS));
  assign mapped      = hit_dfh | hit_scratch | hit_testpad | hit_cap;

  assign req_ready = (fifo_count != 2'd2) && !rst;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !req_write;
  assign rsp_valid = (fifo_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    cap_status = '0;
    cap_status[CAP_ATS_LSB    +: 8] = 8'(ATS_CAP_EN);
    cap_status[CAP_VF_ATS_LSB +: 8] = 8'(VF_ATS_CAP_EN);
    cap_status[CAP_PRS_LSB    +: 8] = 8'(PRS_CAP_EN);
    cap_status[CAP_PASID_LSB  +: 8] = 8'(PASID_CAP_EN);
    cap_status[CAP_NPFS_LSB   +: 8] = 8'(NUM_PFS);
    cap_status[CAP_NLINK_LSB  +: 8] = 8'(NUM_LINKS);
  end

  always_comb begin
    rd_data = '0;
    if (hit_dfh)     rd_data = DFH_VALUE;
    if (hit_scratch) rd_data = scratchpad;
    if (hit_testpad) rd_data = testpad;
    if (hit_cap)     rd_data = cap_status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratchpad <= '0;
      testpad    <= '0;
      err_cnt    <= '0;
    end else if (accept) begin
      if (!mapped) begin
        err_cnt <= sat_inc16(err_cnt);
      end else if (req_write) begin
        if (hit_scratch) scratchpad <= apply_be(scratchpad, req_wdata, req_be);
        if (hit_testpad) testpad    <= apply_be(testpad, req_wdata, req_be);
      end
    end
  end

  // Read data is captured at the accept edge and queued with its tag.
  assign push_data.rdata = rd_data;
  assign push_data.tag   = CSR_TAG_W'(req_tag);
  assign push_data.err   = !mapped;

  pcie_csr_rsp_fifo u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign rsp_rdata = head.rdata;
  assign rsp_tag   = TAG_W'(head.tag);
  assign rsp_err   = head.err;

endmodule
